// File: rtl/main_mem_responder_pkg.sv
// Shared memory-interface widths and local types for the main-memory responder.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif

package main_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  // Counter width that stays at least one bit even for a single-beat line.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/main_mem_ram.sv
// Single-port byte-writable RAM with a registered (1-cycle) read; no reset.
module main_mem_ram #(
  parameter int unsigned DATA_BITS = 128,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic                   clk,
  input  logic [DATA_BITS/8-1:0] we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_BITS-1:0]   wdata,
  output logic [DATA_BITS-1:0]   rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_W];

  // Per-byte write and synchronous read on the same address.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DATA_BITS/8; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: accepts line reads/writes, returns tagged read beats
// after a fixed latency, backed by main_mem_ram.
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = `MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS   = `MEM_DATA_BITS,
  parameter int unsigned TAG_BITS    = `MEM_TAG_BITS,
  parameter int unsigned DATA_CYCLES = 4,
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);

  localparam int unsigned CNT_W      = cnt_width(DATA_CYCLES);
  localparam int unsigned BEAT_SHIFT = $clog2(DATA_CYCLES);
  localparam int unsigned RAM_AW     = DEPTH_LOG2 + BEAT_SHIFT;
  localparam int unsigned LAT_W      = $clog2(LATENCY);
  localparam int unsigned MASK_W     = DATA_BITS / 8;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 2);

  state_t                state, next_state;
  logic [DEPTH_LOG2-1:0] line_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [CNT_W-1:0]      beat_q;
  logic [LAT_W-1:0]      lat_q;

  logic                  ready_q, data_ready_q, resp_valid_q;
  logic [TAG_BITS-1:0]   resp_tag_q;
  logic                  ready_d, data_ready_d, resp_valid_d;

  logic [MASK_W-1:0]     ram_we;
  logic [CNT_W-1:0]      ram_idx;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_BITS-1:0]  ram_rdata;

  logic                  req_fire, beat_fire, last_beat, lat_done;
  logic                  addr_unused;

  assign req_fire    = mem_req_valid && ready_q;
  assign beat_fire   = mem_req_data_valid && data_ready_q;
  assign last_beat   = (beat_q == LAST_BEAT);
  assign lat_done    = (lat_q == LAT_LAST);
  // Line address aliases modulo 2^DEPTH_LOG2; the upper bits are dropped.
  assign addr_unused = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_fire) next_state = mem_req_rw ? WR_DATA : RD_WAIT;
      WR_DATA: if (beat_fire && last_beat) next_state = IDLE;
      RD_WAIT: if (lat_done) next_state = RD_RESP;
      RD_RESP: if (last_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/RAM-control decode; handshake and response flags are computed one
  // cycle early so that every port is driven straight from a flop.
  always_comb begin
    ram_we       = '0;
    ram_idx      = beat_q;
    ready_d      = (next_state == IDLE);
    data_ready_d = (next_state == WR_DATA);
    resp_valid_d = 1'b0;
    unique case (state)
      WR_DATA: if (beat_fire && !reset) ram_we = mem_req_data_mask;
      RD_WAIT: resp_valid_d = lat_done;
      RD_RESP: begin
        ram_idx      = beat_q + CNT_W'(1);
        resp_valid_d = !last_beat;
      end
      default: ;
    endcase
  end

  if (BEAT_SHIFT == 0) begin : g_single_beat
    assign ram_addr = line_q;
  end else begin : g_multi_beat
    assign ram_addr = {line_q, ram_idx[BEAT_SHIFT-1:0]};
  end

  // Request latches, beat/latency counters and registered handshake/response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= 1'b0;
      data_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      line_q       <= '0;
      tag_q        <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
    end else begin
      ready_q      <= ready_d;
      data_ready_q <= data_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_valid_d ? tag_q : '0;
      unique case (state)
        IDLE: if (req_fire) begin
          line_q <= mem_req_addr[DEPTH_LOG2-1:0];
          tag_q  <= mem_req_tag;
          beat_q <= '0;
          lat_q  <= '0;
        end
        WR_DATA: if (beat_fire) beat_q <= beat_q + CNT_W'(1);
        RD_WAIT: if (!lat_done) lat_q <= lat_q + LAT_W'(1);
        RD_RESP: beat_q <= beat_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  main_mem_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_W   (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(mem_req_data_bits),
    .rdata(ram_rdata)
  );

  assign mem_req_ready      = ready_q;
  assign mem_req_data_ready = data_ready_q;
  assign mem_resp_valid     = resp_valid_q;
  assign mem_resp_tag       = resp_tag_q;
  // The RAM read register has no reset, so data is qualified by the
  // registered valid to hold the port at zero outside response beats.
  assign mem_resp_data      = resp_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed, table-driven bench for main_mem_responder.
module tb_main_mem_responder;

  localparam int L  = 3;
  localparam int DC = 4;

  typedef struct {
    bit                 rw;
    logic [31:0]        addr;
    logic [7:0]         tag;
    logic [3:0][127:0]  data;  // write beats, or expected read beats
    logic [3:0][15:0]   mask;
    int                 gap;   // idle data cycles between beats 1 and 2
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [7:0]   mem_req_tag;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [7:0]   mem_resp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  main_mem_responder #(
    .ADDR_BITS  (32),
    .DATA_BITS  (128),
    .TAG_BITS   (8),
    .DATA_CYCLES(DC),
    .DEPTH_LOG2 (12),
    .LATENCY    (L)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_rw        (mem_req_rw),
    .mem_req_addr      (mem_req_addr),
    .mem_req_tag       (mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .mem_resp_tag      (mem_resp_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input bit rw, input logic [31:0] a, input logic [7:0] t,
                               input logic [3:0][127:0] d, input logic [3:0][15:0] m,
                               input int gap);
    vec_t v;
    v.rw = rw; v.addr = a; v.tag = t; v.data = d; v.mask = m; v.gap = gap;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (mem_req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_req_ready", mem_req_ready, 1);
  endtask

  task automatic do_write(input vec_t v);
    wait_ready();
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = v.addr; mem_req_tag = v.tag;
    tick();
    mem_req_valid = 1'b0; mem_req_rw = 1'b0;
    chk("wr_req_ready_low", mem_req_ready, 0);
    for (int k = 0; k < DC; k++) begin
      if (k == 2) begin
        for (int g = 0; g < v.gap; g++) begin
          chk("wr_gap_data_ready", mem_req_data_ready, 1);
          chk("wr_gap_req_ready", mem_req_ready, 0);
          tick();
        end
      end
      chk("wr_data_ready", mem_req_data_ready, 1);
      chk("wr_no_resp", mem_resp_valid, 0);
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = v.data[k];
      mem_req_data_mask  = v.mask[k];
      tick();
      mem_req_data_valid = 1'b0;
    end
    chk("wr_done_req_ready", mem_req_ready, 1);
    chk("wr_done_data_ready", mem_req_data_ready, 0);
  endtask

  task automatic do_read(input vec_t v);
    wait_ready();
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = v.addr; mem_req_tag = v.tag;
    tick();
    mem_req_valid = 1'b0;
    for (int c = 1; c <= L + DC; c++) begin
      bit ev;
      ev = (c >= L) && (c < L + DC);
      chk("rd_resp_valid", mem_resp_valid, ev);
      if (ev) begin
        chk("rd_resp_data", mem_resp_data, v.data[c-L]);
        chk("rd_resp_tag", mem_resp_tag, v.tag);
      end
      chk("rd_req_ready", mem_req_ready, c == L + DC);
      chk("rd_data_ready", mem_req_data_ready, 0);
      if (c < L + DC) tick();
    end
  endtask

  vec_t tbl[12];
  localparam logic [3:0][15:0] FULL = {4{16'hFFFF}};

  initial begin
    logic [3:0][127:0] base, part, gapd, alias_d, l1, l2;
    int beats;

    base    = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    part    = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {{15{8'h11}}, 8'hFF}};
    gapd    = {{16{8'hD4}}, {16{8'hC3}}, {16{8'hB2}}, {16{8'hA1}}};
    alias_d = {128'h55AA55AA00FF00FF_33CC33CCF0F00F0F, 128'hFEDCBA9876543210_0123456789ABCDEF,
               128'h8899AABBCCDDEEFF_0F1E2D3C4B5A6978, 128'h0123456789ABCDEF_0011223344556677};
    l1      = {{4{32'h0001_0003}}, {4{32'h0001_0002}}, {4{32'h0001_0001}}, {4{32'h0001_0000}}};
    l2      = {{4{32'h0002_0003}}, {4{32'h0002_0002}}, {4{32'h0002_0001}}, {4{32'h0002_0000}}};

    tbl[0]  = mkv(1, 32'h10,   8'd3, base, FULL, 0);
    tbl[1]  = mkv(0, 32'h10,   8'd5, base, FULL, 0);
    tbl[2]  = mkv(1, 32'h10,   8'd3,
                  {{16{8'hEE}}, {16{8'hDD}}, {16{8'hCC}}, {16{8'hFF}}},
                  {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 0);
    tbl[3]  = mkv(0, 32'h10,   8'd6, part, FULL, 0);
    tbl[4]  = mkv(1, 32'h20,   8'd1, gapd, FULL, 3);
    tbl[5]  = mkv(0, 32'h20,   8'd2, gapd, FULL, 0);
    tbl[6]  = mkv(1, 32'h1007, 8'd0, alias_d, FULL, 0);
    tbl[7]  = mkv(0, 32'h7,    8'd7, alias_d, FULL, 0);
    tbl[8]  = mkv(1, 32'h1,    8'd0, l1, FULL, 0);
    tbl[9]  = mkv(1, 32'h2,    8'd0, l2, FULL, 0);
    tbl[10] = mkv(0, 32'h1,    8'd1, l1, FULL, 0);
    tbl[11] = mkv(0, 32'h2,    8'd2, l2, FULL, 0);

    reset = 1'b1; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
    mem_req_data_valid = 1'b0; mem_req_data_bits = '0; mem_req_data_mask = '0;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", mem_req_ready, 0);
    chk("rst_data_ready", mem_req_data_ready, 0);
    chk("rst_resp_valid", mem_resp_valid, 0);
    chk("rst_resp_data", mem_resp_data, 0);
    chk("rst_resp_tag", mem_resp_tag, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", mem_req_ready, 1);
    chk("post_rst_data_ready", mem_req_data_ready, 0);

    // Table: write/read, partial mask, gaps, alias, setup of lines 1 and 2
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rw) do_write(tbl[i]);
      else           do_read(tbl[i]);
    end

    // Back-to-back reads with mem_req_valid held high
    wait_ready();
    beats = 0;
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 32'h1; mem_req_tag = 8'd1;
    tick();
    mem_req_addr = 32'h2; mem_req_tag = 8'd2;
    for (int c = 1; c <= 2 * (L + DC); c++) begin
      int  c2;
      bit  ev;
      c2 = (c <= L + DC) ? c : c - (L + DC);
      ev = (c2 >= L) && (c2 < L + DC);
      if (mem_resp_valid === 1'b1) beats++;
      chk("b2b_resp_valid", mem_resp_valid, ev);
      if (ev) begin
        chk("b2b_resp_data", mem_resp_data, (c <= L + DC) ? l1[c2-L] : l2[c2-L]);
        chk("b2b_resp_tag", mem_resp_tag, (c <= L + DC) ? 8'd1 : 8'd2);
      end
      chk("b2b_req_ready", mem_req_ready, c2 == L + DC);
      if (c < 2 * (L + DC)) tick();
      if (c == L + DC) mem_req_valid = 1'b0;
    end
    chk("b2b_beat_count", beats, 2 * DC);

    // Reset during RD_RESP after beat 1
    wait_ready();
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 32'h10; mem_req_tag = 8'd9;
    tick();
    mem_req_valid = 1'b0;
    for (int c = 1; c < L + 1; c++) tick();
    chk("mid_rst_beat1_valid", mem_resp_valid, 1);
    chk("mid_rst_beat1_data", mem_resp_data, part[1]);
    reset = 1'b1;
    tick();
    chk("mid_rst_resp_valid", mem_resp_valid, 0);
    chk("mid_rst_resp_data", mem_resp_data, 0);
    chk("mid_rst_resp_tag", mem_resp_tag, 0);
    chk("mid_rst_req_ready", mem_req_ready, 0);
    reset = 1'b0;
    tick();
    chk("after_rst_req_ready", mem_req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      chk("after_rst_no_resp", mem_resp_valid, 0);
      tick();
    end
    do_read(tbl[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
